ripple_count_monitor: RTL

Synchronous consumer for the 3-bit ripple-counter output. It samples the ripple bits into the `clk` domain and rejects settling glitches with a stability filter. It extends the 3-bit value to a wider total count by counting 7->0 wraps, flags illegal jumps, and hands each accepted count change downstream over a valid/ready interface. It sits directly after the 3-bit ripple counter and consumes its Q bus.

---
 rtl/ripple_count_monitor.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ripple_count_monitor.sv
// rtl/ripple_count_monitor.sv - synchronizes, filters and extends a 3-bit ripple count
module ripple_count_monitor #(
  parameter int EXT_W         = 5,
  parameter int STABLE_CYCLES = 2,
  localparam int W            = 3 + EXT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   q_in,
  input  logic         clear,
  input  logic [W-1:0] threshold,
  output logic [W-1:0] total,
  output logic         step,
  output logic         wrap,
  output logic         match,
  output logic         err,
  output logic         evt_valid,
  input  logic         evt_ready,
  output logic [W-1:0] evt_count,
  output logic         evt_err,
  output logic         ovf
);

  typedef enum logic {
    ACQUIRE = 1'b0,
    TRACK   = 1'b1
  } state_t;

  localparam logic [2:0] HOLD_MAX = 3'(STABLE_CYCLES);

  state_t             state;
  state_t             state_n;
  logic [2:0]         sync1;
  logic [2:0]         sync2;
  logic [2:0]         hold;
  logic [2:0]         cur;
  logic [EXT_W-1:0]   ext;

  logic               cand_valid;
  logic               accept;
  logic               load_cur;
  logic               is_step;
  logic               is_wrap;
  logic [2:0]         diff;
  logic [EXT_W-1:0]   ext_n;
  logic [W-1:0]       total_n;

  assign total = {ext, cur};

  // Two-flop synchronizer plus hold counter measuring how long sync2 has been steady
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 3'd0;
      sync2 <= 3'd0;
      hold  <= 3'd0;
    end else begin
      sync1 <= q_in;
      sync2 <= sync1;
      if (clear || (sync1 != sync2)) begin
        hold <= 3'd0;
      end else if (hold != HOLD_MAX) begin
        hold <= hold + 3'd1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ACQUIRE;
    end else begin
      state <= state_n;
    end
  end

  // Next state plus classification of the steady candidate against the current count
  always_comb begin
    state_n    = state;
    cand_valid = (hold == HOLD_MAX);
    accept     = 1'b0;
    load_cur   = 1'b0;
    diff       = sync2 - cur;
    case (state)
      ACQUIRE: begin
        if (cand_valid) begin
          load_cur = 1'b1;
          state_n  = TRACK;
        end
      end
      TRACK: begin
        if (cand_valid && (sync2 != cur)) begin
          accept   = 1'b1;
          load_cur = 1'b1;
        end
      end
    endcase
    is_step = accept && (diff == 3'd1);
    is_wrap = is_step && (cur == 3'd7);
    ext_n   = ext + EXT_W'(is_wrap);
    total_n = {ext_n, sync2};
    if (clear) begin
      state_n = ACQUIRE;
    end
  end

  // Count tracking: low bits, wrap extension, sticky error and one-cycle pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur   <= 3'd0;
      ext   <= '0;
      err   <= 1'b0;
      step  <= 1'b0;
      wrap  <= 1'b0;
      match <= 1'b0;
    end else if (clear) begin
      cur   <= 3'd0;
      ext   <= '0;
      err   <= 1'b0;
      step  <= 1'b0;
      wrap  <= 1'b0;
      match <= 1'b0;
    end else begin
      step  <= is_step;
      wrap  <= is_wrap;
      match <= is_step && (total_n == threshold);
      ext   <= ext_n;
      if (load_cur) begin
        cur <= sync2;
      end
      if (accept && !is_step) begin
        err <= 1'b1;
      end
    end
  end

  // Single-entry event record; a new event while the record is stuck is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_valid <= 1'b0;
      evt_count <= '0;
      evt_err   <= 1'b0;
      ovf       <= 1'b0;
    end else if (clear) begin
      evt_valid <= 1'b0;
      evt_count <= '0;
      evt_err   <= 1'b0;
      ovf       <= 1'b0;
    end else if (accept) begin
      if (!evt_valid || evt_ready) begin
        evt_valid <= 1'b1;
        evt_count <= total_n;
        evt_err   <= !is_step;
      end else begin
        ovf <= 1'b1;
      end
    end else if (evt_valid && evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

endmodule
